// File: rtl/instruction_fetch_register.sv
// Fetch stage of the 16-bit multicycle TSC CPU: issues a word read, waits for
// the memory ready handshake and latches the returned word into the IR.
module instruction_fetch_register #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] address,
    output logic                 readM,
    input  logic [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    output logic [WORD_SIZE-1:0] instruction,
    output logic                 ir_valid,
    output logic [3:0]           opcode,
    output logic [1:0]           rs,
    output logic [1:0]           rt,
    output logic [1:0]           rd,
    output logic [5:0]           func,
    output logic [7:0]           imm,
    output logic [11:0]          target_address,
    output logic                 fetch_busy,
    output logic                 fetch_error,
    output logic [WORD_SIZE-1:0] num_inst
);

    // state | meaning
    // IDLE  | no fetch outstanding; IR holds the last completed fetch
    // REQ   | read strobe driven, waiting for inputReady / flush / timeout
    typedef enum logic {IDLE, REQ} state_t;

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (fetch_req) state_next = REQ;
            REQ:  if (flush || inputReady || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Flush wins over a simultaneous inputReady; ready wins over the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address     <= '0;
            readM       <= 1'b0;
            instruction <= '0;
            ir_valid    <= 1'b0;
            fetch_error <= 1'b0;
            num_inst    <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        address     <= pc;
                        readM       <= 1'b1;
                        ir_valid    <= 1'b0;
                        fetch_error <= 1'b0;
                        wait_cnt    <= '0;
                    end else if (flush) begin
                        ir_valid <= 1'b0;
                    end
                end
                REQ: begin
                    if (flush) begin
                        readM <= 1'b0;
                    end else if (inputReady) begin
                        instruction <= data;
                        ir_valid    <= 1'b1;
                        readM       <= 1'b0;
                        num_inst    <= num_inst + 1'b1;
                    end else if (timeout_hit) begin
                        readM       <= 1'b0;
                        fetch_error <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: readM <= 1'b0;
            endcase
        end
    end

    assign fetch_busy     = (state == REQ);
    assign opcode         = instruction[15:12];
    assign rs             = instruction[11:10];
    assign rt             = instruction[9:8];
    assign rd             = instruction[7:6];
    assign func           = instruction[5:0];
    assign imm            = instruction[7:0];
    assign target_address = instruction[11:0];

endmodule

// File: doc/instruction_fetch_register.md
Name: instruction_fetch_register

Overview:
- Fetch stage of the 16-bit multicycle TSC CPU; sits directly upstream of the immediate generator and control unit.
- On a fetch request from control, drives a word read to instruction memory and waits for the memory ready handshake.
- Latches the returned word into the instruction register and splits it into fields, including imm[7:0] and target_address[11:0] for the immediate generator.
- Also provides a retired-fetch counter, a memory-timeout error flag and a flush abort.

Parameters:
- WORD_SIZE, 16, datapath/instruction width; field positions below assume 16.
- TIMEOUT, 64, maximum wait cycles for inputReady in REQ; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request from control; honoured only in IDLE.
- flush  in  1  abort the in-flight fetch (branch/jump redirect).
- pc  in  WORD_SIZE  fetch address; sampled on the accepting edge.
- address  out  WORD_SIZE  registered memory address.
- readM  out  1  memory read strobe (registered).
- data  in  WORD_SIZE  memory read data; valid when inputReady=1.
- inputReady  in  1  memory ready/data-valid.
- instruction  out  WORD_SIZE  instruction register.
- ir_valid  out  1  instruction holds a completed fetch.
- opcode  out  4  instruction[15:12].
- rs  out  2  instruction[11:10].
- rt  out  2  instruction[9:8].
- rd  out  2  instruction[7:6].
- func  out  6  instruction[5:0].
- imm  out  8  instruction[7:0], to the immediate generator.
- target_address  out  12  instruction[11:0].
- fetch_busy  out  1  high while in REQ.
- fetch_error  out  1  sticky timeout flag.
- num_inst  out  WORD_SIZE  count of completed fetches.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; address, readM, instruction, ir_valid, fetch_error, num_inst and the wait counter all 0.
  - Reset asserted mid-REQ drops readM immediately, with no wait for a clock edge.
- Field outputs: purely combinational slices of instruction; no extra latency.
- fetch_busy: combinational, = (state==REQ).
- IDLE:
  - fetch_req=1 at an edge → REQ; address←pc, readM←1, ir_valid←0, fetch_error←0, wait counter←0.
  - inputReady is ignored in IDLE.
- REQ, priority order each edge:
  1. flush=1 → IDLE, readM←0. instruction unchanged, ir_valid stays 0, num_inst unchanged. Flush beats a simultaneous inputReady and the data is discarded.
  2. inputReady=1 → IDLE, instruction←data, ir_valid←1, readM←0, num_inst←num_inst+1 (wraps 0xFFFF→0x0000).
  3. TIMEOUT≠0 and wait counter==TIMEOUT-1 → IDLE, readM←0, fetch_error←1, ir_valid stays 0.
  4. Otherwise the wait counter increments and readM and address are held.
- fetch_req while in REQ: ignored, not queued.
- flush in IDLE: clears ir_valid; no other effect.
- fetch_req and flush together in IDLE: the fetch is accepted; flush has no further effect.
- Latency: if fetch_req is sampled at edge k and inputReady is high at edge k+n (n≥1), then ir_valid and instruction are valid after edge k+n.
  - Minimum request-to-valid time is 2 edges.
  - Back-to-back fetch throughput is 1 instruction per 2 cycles (REQ, then IDLE).
- ir_valid and instruction hold until the next accepted fetch_req, a flush or reset.
- fetch_error is sticky until the next accepted fetch_req or reset.
- Wait counter width is clog2(TIMEOUT)+1; it never overflows.

Test Plan:
- Basic fetch: reset, then pc=0x0010 and fetch_req pulse. Memory returns data=0x6A3C with inputReady high 3 cycles after readM rises.
  - Expect address=0x0010, readM high exactly 3 cycles, instruction=0x6A3C, ir_valid=1.
  - Expect opcode=6, rs=2, rt=2, rd=0, func=0x3C, imm=0x3C, target_address=0xA3C, num_inst=1.
- Flush priority: fetch pc=0x0020, then assert flush and inputReady (data=0xFFFF) on the same edge.
  - Expect readM=0, IDLE, instruction unchanged, ir_valid=0, num_inst unchanged.
- Timeout: TIMEOUT=4, fetch with inputReady never asserted.
  - Expect readM high for exactly 4 cycles, then fetch_error=1 and fetch_busy=0.
  - The next fetch_req clears fetch_error.
- Ignored request and stray ready: fetch_req re-pulsed during REQ with a different pc → address unchanged and one fetch completes.
  - inputReady pulsed in IDLE → no change to instruction or num_inst.
- Async reset mid-fetch: assert reset between clock edges while readM=1.
  - Expect readM, ir_valid and num_inst to go 0 before the next edge; after release the FSM is in IDLE.
- Counter wrap: preload via 65535 back-to-back fetches, or force num_inst=0xFFFF, then one more fetch → num_inst=0x0000.
